// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and width helpers for the adder result accumulator
package adder_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    localparam int ADDER_DATA_W = 8;
    localparam int ADDER_ACC_W  = 16;

    // Counter must be able to hold the value COUNT itself.
    function automatic int cnt_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/adder_acc_fsm.sv
// rtl/adder_acc_fsm.sv - batch counter and handshake control; emits load/clear strobes to the datapath
module adder_acc_fsm
    import adder_pkg::*;
#(
    parameter int COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic busy,
    output logic load,
    output logic clear
);

    localparam int CW = cnt_width(COUNT);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    acc_state_t      state;
    logic [CW-1:0]   cnt;

    assign load  = in_valid && in_ready;
    assign clear = out_valid && out_ready;

    // Handshake outputs are registered alongside state so they never depend on in_*/out_* combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            busy <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/adder_result_accum.sv
// rtl/adder_result_accum.sv - sums COUNT adder results per batch; ADDER_ACC_SATURATE_EN selects saturating accumulation
module adder_result_accum
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = ADDER_DATA_W,
    parameter int ACC_WIDTH  = ADDER_ACC_W,
    parameter int COUNT      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic                  out_overflow,
    output logic                  busy
);

    localparam int SW = ACC_WIDTH + 1;

    logic                 load;
    logic                 clear;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;
    logic [SW-1:0]        sum;
    logic                 carry;

    adder_acc_fsm #(.COUNT(COUNT)) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .busy      (busy),
        .load      (load),
        .clear     (clear)
    );

    assign sum   = {1'b0, acc} + SW'(in_data);
    assign carry = sum[ACC_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            ovf <= ovf | carry;
`ifdef ADDER_ACC_SATURATE_EN
            // Once pinned at all-ones any non-zero add carries again, so it stays pinned.
            acc <= carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
            acc <= sum[ACC_WIDTH-1:0];
`endif
        end
    end

    assign out_sum      = acc;
    assign out_overflow = ovf;

endmodule

// File: tb/tb_adder_result_accum.sv
// tb/tb_adder_result_accum.sv - directed self-checking bench for adder_result_accum
module tb_adder_result_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_overflow;
    logic        busy;

    logic        o_in_valid = 1'b0;
    logic        o_in_ready;
    logic [7:0]  o_in_data = 8'd0;
    logic        o_out_valid;
    logic        o_out_ready = 1'b0;
    logic [7:0]  o_out_sum;
    logic        o_out_overflow;
    logic        o_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adder_result_accum u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    adder_result_accum #(.DATA_WIDTH(8), .ACC_WIDTH(8), .COUNT(2)) u_ovf (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (o_in_valid),
        .in_ready     (o_in_ready),
        .in_data      (o_in_data),
        .out_valid    (o_out_valid),
        .out_ready    (o_out_ready),
        .out_sum      (o_out_sum),
        .out_overflow (o_out_overflow),
        .busy         (o_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++;
        if (out_sum !== 16'd0) begin miscompares++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] v [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = v[i];
            tick();
            if (i == 0) begin
                vectors++;
                if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_first got %b want 1", busy); end
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
        vectors++;
        if (out_sum !== 16'd100) begin miscompares++; $display("FAIL basic_sum got %0d want 100", out_sum); end
        vectors++;
        if (out_overflow !== 1'b0) begin miscompares++; $display("FAIL basic_ovf got %b want 0", out_overflow); end
        vectors++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_done_flags got ready=%b busy=%b want 0 0", in_ready, busy); end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_after_hs got valid=%b ready=%b want 0 1", out_valid, in_ready); end
        vectors++;
        if (out_sum !== 16'd0) begin miscompares++; $display("FAIL basic_cleared got %0d want 0", out_sum); end
    endtask

    task automatic test_backpressure();
        logic [7:0] v [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = v[i];
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 8'd99;
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_sum !== 16'd100 || in_ready !== 1'b0)
                begin miscompares++; $display("FAIL bp_hold cyc%0d got valid=%b sum=%0d ready=%b want 1 100 0", i, out_valid, out_sum, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'd1;
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 16'd4) begin miscompares++; $display("FAIL bp_next_batch got valid=%b sum=%0d want 1 4", out_valid, out_sum); end
        tick();
    endtask

    task automatic test_gaps();
        logic [7:0] v [4] = '{8'd127, 8'd127, 8'd0, 8'd1};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = v[i];
            tick();
            in_valid = 1'b0;
            in_data = 8'hAA;
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    vectors++;
                    if (busy !== 1'b1) begin miscompares++; $display("FAIL gaps_busy i%0d g%0d got %b want 1", i, g, busy); end
                end
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 16'd255 || busy !== 1'b0)
            begin miscompares++; $display("FAIL gaps_result got valid=%b sum=%0d busy=%b want 1 255 0", out_valid, out_sum, busy); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_sum;
`ifdef ADDER_ACC_SATURATE_EN
        exp_sum = 8'd255;
`else
        exp_sum = 8'd44;
`endif
        o_out_ready = 1'b0;
        o_in_valid = 1'b1;
        o_in_data = 8'd200;
        tick();
        o_in_data = 8'd100;
        tick();
        o_in_valid = 1'b0;
        vectors++;
        if (o_out_valid !== 1'b1 || o_out_sum !== exp_sum || o_out_overflow !== 1'b1)
            begin miscompares++; $display("FAIL ovf_batch got valid=%b sum=%0d ovf=%b want 1 %0d 1", o_out_valid, o_out_sum, o_out_overflow, exp_sum); end
        o_out_ready = 1'b1;
        tick();
        o_in_valid = 1'b1;
        o_in_data = 8'd1;
        tick();
        o_in_data = 8'd2;
        tick();
        o_in_valid = 1'b0;
        vectors++;
        if (o_out_valid !== 1'b1 || o_out_sum !== 8'd3 || o_out_overflow !== 1'b0)
            begin miscompares++; $display("FAIL ovf_next got valid=%b sum=%0d ovf=%b want 1 3 0", o_out_valid, o_out_sum, o_out_overflow); end
        tick();
        o_out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd5;
        tick();
        in_data = 8'd6;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || out_sum !== 16'd0) begin miscompares++; $display("FAIL midrst_clear got busy=%b sum=%0d want 0 0", busy, out_sum); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'd1;
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 16'd4) begin miscompares++; $display("FAIL midrst_batch got valid=%b sum=%0d want 1 4", out_valid, out_sum); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_overflow();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
